// File: rtl/monobit_stream_gen.sv
// monobit_stream_gen: serial test-bit source for the monobit frequency-test
// core. Emits BLOCK_LEN bits per start command from a 16-bit Fibonacci LFSR
// or from a fixed pattern, and counts the ones actually accepted downstream.
//
// Handshake: epsilon_rsc_dat is valid whenever epsilon_vld=1; a bit is
// transferred on every rising edge where epsilon_vld & epsilon_rdy are both
// high. The bit, LFSR and counters hold while epsilon_rdy=0, and
// epsilon_triosy_lz strobes combinationally in the transfer cycle.
//
// state_dbg and bit_count are observation outputs (FSM state encoding
// IDLE=0, RUN=1, DONE=2, and the number of bits accepted in the current or
// last block).
module monobit_stream_gen #(
  parameter int          BLOCK_LEN = 128,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          CW        = $clog2(BLOCK_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [15:0]   seed_in,
  output logic          epsilon_rsc_dat,
  output logic          epsilon_vld,
  input  logic          epsilon_rdy,
  output logic          epsilon_triosy_lz,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] ones_count,
  output logic [1:0]    state_dbg,
  output logic [CW-1:0] bit_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    mode_q;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_nxt;
  logic [15:0]   seed_eff;
  logic          phase;
  logic          dat_q;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] ones_cnt;
  logic          accept;
  logic          xfer;
  logic          last_xfer;

  // Polynomial x^16+x^14+x^13+x^11+1 in shift-right Fibonacci form.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  // Bit presented for a given mode, LFSR value and alternating phase.
  function automatic logic pick_bit(input logic [1:0] m, input logic [15:0] l,
                                    input logic ph);
    logic b;
    case (m)
      2'd0:    b = l[0];
      2'd1:    b = 1'b1;
      2'd2:    b = 1'b0;
      default: b = ph;
    endcase
    return b;
  endfunction

  // Shared control terms; abort blocks a start in the same cycle.
  always_comb begin
    seed_eff  = (seed_in == 16'd0) ? SEED : seed_in;
    lfsr_nxt  = lfsr_step(lfsr);
    accept    = (state == IDLE) && start && !abort;
    xfer      = (state == RUN) && epsilon_rdy;
    last_xfer = xfer && (bit_cnt == CW'(BLOCK_LEN - 1));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic; abort wins over start and over the end-of-block move.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN: begin
        if (abort)          state_next = IDLE;
        else if (last_xfer) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: block setup on an accepted start, advance on each transfer.
  // A transfer coinciding with abort still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= 2'd0;
      lfsr     <= SEED;
      phase    <= 1'b1;
      dat_q    <= 1'b0;
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (accept) begin
      mode_q   <= mode;
      lfsr     <= seed_eff;
      phase    <= 1'b1;
      dat_q    <= pick_bit(mode, seed_eff, 1'b1);
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (xfer) begin
      lfsr     <= lfsr_nxt;
      phase    <= ~phase;
      dat_q    <= pick_bit(mode_q, lfsr_nxt, ~phase);
      bit_cnt  <= bit_cnt + CW'(1);
      ones_cnt <= ones_cnt + {{(CW-1){1'b0}}, dat_q};
    end
  end

  // FSM outputs and strobes decoded from the current state.
  always_comb begin
    epsilon_vld       = (state == RUN);
    busy              = (state == RUN);
    done              = (state == DONE);
    epsilon_triosy_lz = (state == RUN) && epsilon_rdy;
    epsilon_rsc_dat   = dat_q;
    ones_count        = ones_cnt;
    bit_count         = bit_cnt;
    state_dbg         = state;
  end

endmodule

// File: tb/tb_monobit_stream_gen.sv
// Testbench for monobit_stream_gen: directed block scenarios with random
// seeds and random back-pressure, checked against a bit-sequence model.
module tb_monobit_stream_gen;

  localparam int          BLOCK_LEN = 128;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          CW        = $clog2(BLOCK_LEN + 1);

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [15:0]   seed_in;
  logic          epsilon_rsc_dat;
  logic          epsilon_vld;
  logic          epsilon_rdy;
  logic          epsilon_triosy_lz;
  logic          busy;
  logic          done;
  logic [CW-1:0] ones_count;
  logic [1:0]    state_dbg;
  logic [CW-1:0] bit_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard: bits the block should deliver, in order.
  logic [0:0] exp_q[$];
  logic [0:0] obs_bits[$];
  int         last_ones;

  monobit_stream_gen #(
    .BLOCK_LEN(BLOCK_LEN),
    .SEED     (SEED),
    .CW       (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .mode             (mode),
    .seed_in          (seed_in),
    .epsilon_rsc_dat  (epsilon_rsc_dat),
    .epsilon_vld      (epsilon_vld),
    .epsilon_rdy      (epsilon_rdy),
    .epsilon_triosy_lz(epsilon_triosy_lz),
    .busy             (busy),
    .done             (done),
    .ones_count       (ones_count),
    .state_dbg        (state_dbg),
    .bit_count        (bit_count)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the bit stream a block should carry, from the pattern rules.
  // The LFSR emits its low bit, then shifts right, inserting the parity of
  // the tap positions 0,2,3,5 (taps 16,14,13,11 of the polynomial).
  task automatic fill_exp(input logic [1:0] m, input logic [15:0] s);
    logic [15:0] r;
    exp_q.delete();
    r = (s == 16'd0) ? SEED : s;
    for (int i = 0; i < BLOCK_LEN; i++) begin
      case (m)
        2'd0: begin
          exp_q.push_back(r[0]);
          r = {^(r & 16'h002D), r[15:1]};
        end
        2'd1:    exp_q.push_back(1'b1);
        2'd2:    exp_q.push_back(1'b0);
        default: exp_q.push_back((i % 2 == 0) ? 1'b1 : 1'b0);
      endcase
    end
  endtask

  // Driver: one-cycle start pulse; mode/seed are scrambled right after the
  // start edge, which must not disturb the running block.
  task automatic do_start(input logic [1:0] m, input logic [15:0] s);
    @(negedge clk);
    start       = 1'b1;
    abort       = 1'b0;
    epsilon_rdy = 1'b0;
    mode        = m;
    seed_in     = s;
    @(posedge clk);
    #1;
    start   = 1'b0;
    mode    = 2'($urandom_range(0, 3));
    seed_in = 16'($urandom);
  endtask

  // Runs one block. rdy_kind: 0 always ready, 1 toggling 1,0,..., 2 random.
  // abort_at >= 0 asserts abort together with rdy when that many bits have
  // been accepted. extra_start pulses start mid-block.
  task automatic run_block(input string tag, input logic [1:0] m, input logic [15:0] s,
                           input int rdy_kind, input int abort_at, input bit extra_start);
    int xfers    = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_cyc = -1;
    int ones_m   = 0;
    bit aborted  = 1'b0;
    bit exp_run;
    bit exp_done;
    logic [0:0] b;
    fill_exp(m, s);
    obs_bits.delete();
    do_start(m, s);
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      case (rdy_kind)
        0:       epsilon_rdy = 1'b1;
        1:       epsilon_rdy = (cyc % 2 == 0);
        default: epsilon_rdy = 1'($urandom_range(0, 1));
      endcase
      start = extra_start && (cyc == 10);
      abort = (abort_at >= 0) && !aborted && (xfers == abort_at);
      if (abort) epsilon_rdy = 1'b1;
      #1;
      if (aborted) begin
        check({tag, " vld_after_abort"}, 32'(epsilon_vld), 32'd0);
        check({tag, " busy_after_abort"}, 32'(busy), 32'd0);
        check({tag, " done_after_abort"}, 32'(done), 32'd0);
        check({tag, " state_after_abort"}, 32'(state_dbg), 32'd0);
        break;
      end
      exp_run  = (xfers < BLOCK_LEN);
      exp_done = (xfers == BLOCK_LEN) && (cyc == last_cyc + 1);
      check({tag, " vld"}, 32'(epsilon_vld), 32'(exp_run));
      check({tag, " busy"}, 32'(busy), 32'(exp_run));
      check({tag, " done"}, 32'(done), 32'(exp_done));
      if (epsilon_vld && !epsilon_rdy && exp_q.size() > 0)
        check({tag, " held_bit"}, 32'(epsilon_rsc_dat), 32'(exp_q[0]));
      if (epsilon_triosy_lz) begin
        if (exp_q.size() == 0) begin
          check({tag, " extra_transfer"}, 32'(xfers + 1), 32'(BLOCK_LEN));
        end else begin
          b = exp_q.pop_front();
          check({tag, " bit"}, 32'(epsilon_rsc_dat), 32'(b));
          if (b == 1'b1) ones_m++;
        end
        obs_bits.push_back(epsilon_rsc_dat);
        xfers++;
        last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (abort) aborted = 1'b1;
      if (done_cnt > 0 && cyc == done_cyc + 2) break;
    end
    start       = 1'b0;
    abort       = 1'b0;
    epsilon_rdy = 1'b0;
    last_ones   = ones_m;
    if (abort_at < 0) begin
      check({tag, " transfers"}, 32'(xfers), 32'(BLOCK_LEN));
      check({tag, " done_count"}, 32'(done_cnt), 32'd1);
      check({tag, " done_latency"}, 32'(done_cyc), 32'(last_cyc + 1));
      check({tag, " ones_count"}, 32'(ones_count), 32'(ones_m));
      check({tag, " bit_count"}, 32'(bit_count), 32'(BLOCK_LEN));
      if (rdy_kind == 0) check({tag, " last_xfer_cycle"}, 32'(last_cyc), 32'(BLOCK_LEN - 1));
      if (rdy_kind == 1) check({tag, " last_xfer_cycle"}, 32'(last_cyc), 32'(2 * BLOCK_LEN - 2));
    end else begin
      check({tag, " transfers"}, 32'(xfers), 32'(abort_at + 1));
      check({tag, " done_count"}, 32'(done_cnt), 32'd0);
      check({tag, " bit_count"}, 32'(bit_count), 32'(abort_at + 1));
      check({tag, " ones_count"}, 32'(ones_count), 32'(ones_m));
    end
  endtask

  // Stimulus
  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    mode        = 2'd0;
    seed_in     = 16'd0;
    epsilon_rdy = 1'b0;
    #2;
    check("reset vld", 32'(epsilon_vld), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset triosy", 32'(epsilon_triosy_lz), 32'd0);
    check("reset dat", 32'(epsilon_rsc_dat), 32'd0);
    check("reset ones", 32'(ones_count), 32'd0);
    check("reset bit_count", 32'(bit_count), 32'd0);
    check("reset state", 32'(state_dbg), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // All ones at full throughput.
    run_block("ones", 2'd1, 16'd0, 0, -1, 1'b0);
    check("ones total", 32'(ones_count), 32'(BLOCK_LEN));

    // LFSR from the default seed, twice; first bits come from ACE1 then 5670.
    run_block("lfsr_a", 2'd0, 16'd0, 0, -1, 1'b0);
    check("lfsr first bit", 32'(obs_bits[0]), 32'd1);
    check("lfsr second bit", 32'(obs_bits[1]), 32'd0);
    run_block("lfsr_b", 2'd0, 16'd0, 2, -1, 1'b0);

    // Alternating pattern under toggling back-pressure.
    run_block("alt", 2'd3, 16'd0, 1, -1, 1'b0);
    check("alt ones", 32'(ones_count), 32'(BLOCK_LEN / 2));

    // Zeros aborted together with the 41st transfer, then a full block.
    run_block("abort", 2'd2, 16'd0, 0, 40, 1'b0);
    check("abort ones", 32'(ones_count), 32'd0);
    run_block("after_abort", 2'd2, 16'd0, 0, -1, 1'b0);

    // Extra start inside RUN must be ignored.
    run_block("extra_start", 2'd1, 16'd0, 0, -1, 1'b1);

    // Random seeds and random back-pressure.
    for (int k = 0; k < 3; k++) begin
      run_block("rand_lfsr", 2'd0, 16'($urandom_range(1, 65535)), 2, -1, 1'b0);
      check("rand_lfsr ones_model", 32'(ones_count), 32'(last_ones));
    end
    run_block("rand_alt", 2'd3, 16'($urandom), 2, -1, 1'b0);

    // Asynchronous reset in the middle of a block.
    do_start(2'd1, 16'd0);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      epsilon_rdy = 1'b1;
    end
    @(negedge clk);
    epsilon_rdy = 1'b0;
    #1;
    check("pre_rst ones", 32'(ones_count), 32'd50);
    check("pre_rst vld", 32'(epsilon_vld), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst vld", 32'(epsilon_vld), 32'd0);
    check("async_rst busy", 32'(busy), 32'd0);
    check("async_rst ones", 32'(ones_count), 32'd0);
    check("async_rst bit_count", 32'(bit_count), 32'd0);
    check("async_rst state", 32'(state_dbg), 32'd0);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      epsilon_rdy = 1'b1;
      #1;
      check("post_rst idle vld", 32'(epsilon_vld), 32'd0);
      check("post_rst idle triosy", 32'(epsilon_triosy_lz), 32'd0);
    end
    epsilon_rdy = 1'b0;
    run_block("post_rst", 2'd0, 16'h1234, 0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
